// File: rtl/fc_pkg.sv
// Shared definitions for the stream-to-vector collector.
//   WIDTH_DEF / IN_DEF : default activation width and frame length
//   idx_t / cnt_t      : element index and element count at the default frame length
//   fc_col_state_e     : write-side FSM states
package fc_pkg;

   localparam int unsigned WIDTH_DEF = 8;
   localparam int unsigned IN_DEF    = 128;
   localparam int unsigned IDX_W     = $clog2(IN_DEF);
   localparam int unsigned CNT_W     = $clog2(IN_DEF + 1);

   typedef logic [IDX_W-1:0] idx_t;
   typedef logic [CNT_W-1:0] cnt_t;

   typedef enum logic [0:0] {
      FILL  = 1'b0,
      DRAIN = 1'b1
   } fc_col_state_e;

endpackage

// File: rtl/fc_vec_collector_if.sv
// Handshake bundle of the collector.
//   s_valid/s_ready/s_data/s_last : serial activation stream into the collector
//   m_valid/m_ready/m_vec/m_err   : parallel frame out of the collector
// Modports: slave = collector side, master = producer/consumer side.
interface fc_vec_collector_if
   import fc_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF,
   parameter int unsigned IN    = IN_DEF
) ();

   logic             s_valid;
   logic             s_ready;
   logic [WIDTH-1:0] s_data;
   logic             s_last;
   logic             m_valid;
   logic             m_ready;
   logic [WIDTH-1:0] m_vec [0:IN-1];
   logic             m_err;

   modport slave (
      input  s_valid, s_data, s_last, m_ready,
      output s_ready, m_valid, m_vec, m_err
   );

   modport master (
      output s_valid, s_data, s_last, m_ready,
      input  s_ready, m_valid, m_vec, m_err
   );

endinterface

// File: rtl/fc_vec_bank.sv
// One frame storage bank: element memory, element count, error flag and zero-masked output.
//   clk, rst_n : clock, synchronous active-low reset (clears count and error)
//   i_we       : write i_data at element i_idx
//   i_done     : latch i_cnt / i_err as the completed frame's count and error
//   o_vec      : element i = stored value when i < count, else zero
//   o_err      : error flag of the stored frame
module fc_vec_bank
   import fc_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF,
   parameter int unsigned IN    = IN_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_we,
   input  logic [$clog2(IN)-1:0]    i_idx,
   input  logic [WIDTH-1:0]         i_data,
   input  logic                     i_done,
   input  logic [$clog2(IN+1)-1:0]  i_cnt,
   input  logic                     i_err,
   output logic [WIDTH-1:0]         o_vec [0:IN-1],
   output logic                     o_err
);

   localparam int unsigned CntW = $clog2(IN + 1);

   logic [WIDTH-1:0] r_mem [0:IN-1];
   logic [CntW-1:0]  r_cnt;
   logic             r_err;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt <= '0;
         r_err <= 1'b0;
      end else if (i_done) begin
         r_cnt <= i_cnt;
         r_err <= i_err;
      end
   end

   // Memory needs no reset: the count masks anything not written by the current frame.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_idx] <= i_data;
      end
   end

   always_comb begin
      for (int i = 0; i < IN; i++) begin
         o_vec[i] = (CntW'(i) < r_cnt) ? r_mem[i] : '0;
      end
   end

   assign o_err = r_err;

endmodule

// File: rtl/fc_vec_collector.sv
// Stream-to-vector packer feeding a combinational FC layer.
// Collects IN serial WIDTH-bit beats into one frame and presents it as a parallel vector.
//   clk   : clock, all logic on posedge
//   rst_n : synchronous active-low reset
//   bus   : fc_vec_collector_if.slave (s_* serial input, m_* parallel frame output)
// Build option FC_COLLECT_DOUBLE_BUF_EN: two ping-pong banks so a new frame fills while the
// previous one is held for the consumer; undefined gives a single bank.
module fc_vec_collector
   import fc_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF,
   parameter int unsigned IN    = IN_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   fc_vec_collector_if.slave   bus
);

   localparam int unsigned IdxW = $clog2(IN);
   localparam int unsigned CntW = $clog2(IN + 1);
   localparam logic [IdxW-1:0] IdxLast = IdxW'(IN - 1);
   localparam logic [CntW-1:0] CntFull = CntW'(IN);

   fc_col_state_e    r_state, w_state_d;
   logic [IdxW-1:0]  r_idx, w_idx_d;
   logic [1:0]       r_full, w_full_d;
   logic             w_wb, w_rb;
   logic             w_accept, w_we, w_complete, w_release;
   logic [CntW-1:0]  w_cnt;
   logic             w_err;
   logic [WIDTH-1:0] w_vec [0:1][0:IN-1];
   logic [1:0]       w_bank_err;

   // ---------------------------------------------------------------- bank pointers
`ifdef FC_COLLECT_DOUBLE_BUF_EN
   localparam int unsigned NB = 2;

   logic r_wb, r_rb;

   // Both pointers advance in arrival order, so frames leave in the order they were filled.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wb <= 1'b0;
         r_rb <= 1'b0;
      end else begin
         if (w_complete) r_wb <= ~r_wb;
         if (w_release)  r_rb <= ~r_rb;
      end
   end

   assign w_wb = r_wb;
   assign w_rb = r_rb;
`else
   localparam int unsigned NB = 1;

   assign w_wb = 1'b0;
   assign w_rb = 1'b0;
`endif

   // ---------------------------------------------------------------- handshakes
   // DRAIN always accepts so the tail of an over-long frame is flushed.
   assign bus.s_ready = rst_n && ((r_state == DRAIN) || !r_full[w_wb]);
   assign w_accept    = bus.s_valid && bus.s_ready;
   assign w_we        = w_accept && (r_state == FILL);
   assign w_complete  = w_we && (bus.s_last || (r_idx == IdxLast));
   assign w_cnt       = bus.s_last ? (CntW'(r_idx) + CntW'(1)) : CntFull;
   assign w_err       = !(bus.s_last && (r_idx == IdxLast));

   assign bus.m_valid = r_full[w_rb];
   assign w_release   = r_full[w_rb] && bus.m_ready;

   // ---------------------------------------------------------------- write FSM
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= FILL;
         r_idx   <= '0;
         r_full  <= '0;
      end else begin
         r_state <= w_state_d;
         r_idx   <= w_idx_d;
         r_full  <= w_full_d;
      end
   end

   always_comb begin
      w_state_d = r_state;
      w_idx_d   = r_idx;
      unique case (r_state)
         FILL: begin
            if (w_accept) begin
               if (w_complete) begin
                  w_idx_d = '0;
                  if (!bus.s_last) w_state_d = DRAIN;
               end else begin
                  w_idx_d = r_idx + IdxW'(1);
               end
            end
         end
         DRAIN: begin
            if (w_accept && bus.s_last) begin
               w_state_d = FILL;
               w_idx_d   = '0;
            end
         end
      endcase
   end

   // Release and completion always target different banks (or a bank in opposite full states).
   always_comb begin
      w_full_d = r_full;
      if (w_release)  w_full_d[w_rb] = 1'b0;
      if (w_complete) w_full_d[w_wb] = 1'b1;
   end

   // ---------------------------------------------------------------- banks
   for (genvar b = 0; b < 2; b++) begin : g_bank
      if (b < NB) begin : g_on
         fc_vec_bank #(
            .WIDTH (WIDTH),
            .IN    (IN)
         ) u_bank (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_we   (w_we && (w_wb == 1'(b))),
            .i_idx  (r_idx),
            .i_data (bus.s_data),
            .i_done (w_complete && (w_wb == 1'(b))),
            .i_cnt  (w_cnt),
            .i_err  (w_err),
            .o_vec  (w_vec[b]),
            .o_err  (w_bank_err[b])
         );
      end else begin : g_off
         assign w_vec[b]      = '{default: '0};
         assign w_bank_err[b] = 1'b0;
      end
   end

   assign bus.m_vec = w_vec[w_rb];
   assign bus.m_err = w_bank_err[w_rb];

endmodule

// File: tb/tb_fc_vec_collector.sv
// Self-checking bench for fc_vec_collector: scoreboard of expected frames against frames
// observed on the output handshake.
module tb_fc_vec_collector;
   import fc_pkg::*;

   localparam int unsigned W = WIDTH_DEF;
   localparam int unsigned N = IN_DEF;

   typedef struct packed {
      logic         err;
      logic [N*W-1:0] vec;
   } frame_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   n_checks;
   int   n_fail;
   int   valid_cycles;
   int   stalls;
   int   acc_cyc;

   frame_t exp_q[$];
   frame_t obs_q[$];
   int     obs_cyc_q[$];

   fc_vec_collector_if #(.WIDTH(W), .IN(N)) bus ();

   fc_vec_collector #(
      .WIDTH (W),
      .IN    (N)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [N*W-1:0] pack_vec();
      logic [N*W-1:0] v;
      for (int i = 0; i < N; i++) v[i*W +: W] = bus.m_vec[i];
      return v;
   endfunction

   function automatic int first_diff(input logic [N*W-1:0] a, input logic [N*W-1:0] b);
      for (int i = 0; i < N; i++) if (a[i*W +: W] !== b[i*W +: W]) return i;
      return 0;
   endfunction

   // Monitor: records every frame taken by the consumer.
   always @(negedge clk) begin
      frame_t f;
      if (bus.m_valid === 1'b1) valid_cycles++;
      if (rst_n && bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
         f.err = bus.m_err;
         f.vec = pack_vec();
         obs_q.push_back(f);
         obs_cyc_q.push_back(cyc);
      end
   end

   // Tasks start and end at posedge + 1.
   task automatic send_beat(input logic [W-1:0] d, input logic l);
      bit ok = 0;
      bus.s_valid = 1'b1;
      bus.s_data  = d;
      bus.s_last  = l;
      for (int t = 0; t < 2000; t++) begin
         @(negedge clk);
         if (bus.s_ready === 1'b1) begin
            ok      = 1;
            acc_cyc = cyc;
         end else begin
            stalls++;
         end
         @(posedge clk); #1;
         if (ok) break;
      end
      if (!ok) begin
         n_checks++; n_fail++;
         $display("FAIL send_beat: beat %h never accepted (s_ready stuck at %b)", d, bus.s_ready);
      end
   endtask

   // Frame of n beats, data base+k, s_last on the final beat; expected frame from the model.
   task automatic drive_frame(input int n, input logic [W-1:0] base, input bit push);
      frame_t e;
      logic [W-1:0] d;
      e = '0;
      for (int k = 0; k < n; k++) begin
         d = base + W'(k);
         send_beat(d, (k == n - 1));
         if (k < N) e.vec[k*W +: W] = d;
      end
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
      e.err = (n != N);
      if (push) exp_q.push_back(e);
   endtask

   task automatic wait_obs(input int n, output bit ok);
      ok = 0;
      for (int t = 0; t < 1000; t++) begin
         if (obs_q.size() >= n) begin
            ok = 1;
            break;
         end
         @(posedge clk); #1;
      end
      if (!ok) begin
         n_checks++; n_fail++;
         $display("FAIL wait_obs: %0d frames seen, %0d required", obs_q.size(), n);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0; bus.m_ready = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      @(negedge clk);
      n_checks++;
      if (bus.s_ready !== 1'b0) begin
         n_fail++; $display("FAIL reset_s_ready: got %b, required 0", bus.s_ready);
      end
      n_checks++;
      if (bus.m_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_m_valid: got %b, required 0", bus.m_valid);
      end
      n_checks++;
      if (bus.m_err !== 1'b0) begin
         n_fail++; $display("FAIL reset_m_err: got %b, required 0", bus.m_err);
      end
      n_checks++;
      if (pack_vec() !== '0) begin
         n_fail++;
         $display("FAIL reset_m_vec: m_vec[%0d]=%h, required 00",
                  first_diff(pack_vec(), '0), bus.m_vec[first_diff(pack_vec(), '0)]);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.s_ready !== 1'b1) begin
         n_fail++; $display("FAIL post_reset_s_ready: got %b, required 1", bus.s_ready);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_full_frame();
      bit ok;
      int v0;
      int lat_exp;
      frame_t o, e;
      bus.m_ready = 1'b1;
      v0 = valid_cycles;
      drive_frame(N, 8'h00, 1);
      lat_exp = acc_cyc + 1;
      wait_obs(1, ok);
      repeat (3) @(posedge clk);
      #1;
      if (ok) begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         n_checks++;
         if (o.vec !== e.vec) begin
            n_fail++;
            $display("FAIL full_vec: m_vec[%0d]=%h, required %h", first_diff(o.vec, e.vec),
                     o.vec[first_diff(o.vec, e.vec)*W +: W], e.vec[first_diff(o.vec, e.vec)*W +: W]);
         end
         n_checks++;
         if (o.err !== e.err) begin
            n_fail++; $display("FAIL full_err: got %b, required %b", o.err, e.err);
         end
         n_checks++;
         if (obs_cyc_q[0] != lat_exp) begin
            n_fail++; $display("FAIL full_latency: m_valid at cycle %0d, required %0d",
                               obs_cyc_q[0], lat_exp);
         end
         void'(obs_cyc_q.pop_front());
      end
      n_checks++;
      if (valid_cycles - v0 != 1) begin
         n_fail++; $display("FAIL full_valid_pulse: m_valid high %0d cycles, required 1",
                            valid_cycles - v0);
      end
   endtask

   task automatic test_short_frame();
      bit ok;
      frame_t o, e;
      drive_frame(5, 8'h11, 1);
      wait_obs(1, ok);
      if (ok) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); void'(obs_cyc_q.pop_front());
         n_checks++;
         if (o.vec !== e.vec) begin
            n_fail++;
            $display("FAIL short_vec: m_vec[%0d]=%h, required %h", first_diff(o.vec, e.vec),
                     o.vec[first_diff(o.vec, e.vec)*W +: W], e.vec[first_diff(o.vec, e.vec)*W +: W]);
         end
         n_checks++;
         if (o.err !== 1'b1) begin
            n_fail++; $display("FAIL short_err: got %b, required 1", o.err);
         end
      end
   endtask

   task automatic test_long_frame();
      bit ok;
      frame_t o, e;
      drive_frame(N + 2, 8'h80, 1);
      drive_frame(N, 8'h05, 1);
      wait_obs(2, ok);
      if (ok) begin
         for (int f = 0; f < 2; f++) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); void'(obs_cyc_q.pop_front());
            n_checks++;
            if (o.vec !== e.vec) begin
               n_fail++;
               $display("FAIL long_vec frame %0d: m_vec[%0d]=%h, required %h", f,
                        first_diff(o.vec, e.vec), o.vec[first_diff(o.vec, e.vec)*W +: W],
                        e.vec[first_diff(o.vec, e.vec)*W +: W]);
            end
            n_checks++;
            if (o.err !== e.err) begin
               n_fail++; $display("FAIL long_err frame %0d: got %b, required %b", f, o.err, e.err);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      int acc = 0;
      int pos;
      int nf;
      frame_t e, o;
`ifdef FC_COLLECT_DOUBLE_BUF_EN
      nf = 2;
`else
      nf = 1;
`endif
      bus.m_ready = 1'b0;
      e = '0;
      for (int t = 0; t < 300; t++) begin
         pos = acc % N;
         bus.s_valid = 1'b1;
         bus.s_data  = W'(acc * 3 + 1);
         bus.s_last  = (pos == N - 1);
         @(negedge clk);
         if (bus.s_ready === 1'b1) begin
            e.vec[pos*W +: W] = W'(acc * 3 + 1);
            acc++;
            if (pos == N - 1) begin
               e.err = 1'b0;
               exp_q.push_back(e);
               e = '0;
            end
         end
         @(posedge clk); #1;
      end
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
      @(negedge clk);
      n_checks++;
      if (acc != nf * N) begin
         n_fail++; $display("FAIL bp_accepted: %0d beats accepted, required %0d", acc, nf * N);
      end
      n_checks++;
      if (bus.s_ready !== 1'b0) begin
         n_fail++; $display("FAIL bp_s_ready: got %b, required 0", bus.s_ready);
      end
      n_checks++;
      if (bus.m_valid !== 1'b1) begin
         n_fail++; $display("FAIL bp_m_valid: got %b, required 1", bus.m_valid);
      end
      if (exp_q.size() > 0) begin
         n_checks++;
         if (pack_vec() !== exp_q[0].vec) begin
            n_fail++;
            $display("FAIL bp_hold_vec: m_vec[%0d]=%h, required %h",
                     first_diff(pack_vec(), exp_q[0].vec),
                     bus.m_vec[first_diff(pack_vec(), exp_q[0].vec)],
                     exp_q[0].vec[first_diff(pack_vec(), exp_q[0].vec)*W +: W]);
         end
      end
      @(posedge clk); #1;
      bus.m_ready = 1'b1;
      wait_obs(nf, ok);
      if (ok) begin
         for (int f = 0; f < nf; f++) begin
            o = obs_q.pop_front(); void'(obs_cyc_q.pop_front());
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++; $display("FAIL bp_order frame %0d: unexpected extra frame", f);
            end else begin
               e = exp_q.pop_front();
               if (o.vec !== e.vec || o.err !== e.err) begin
                  n_fail++;
                  $display("FAIL bp_order frame %0d: m_vec[0]=%h err=%b, required %h err=%b", f,
                           o.vec[W-1:0], o.err, e.vec[W-1:0], e.err);
               end
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      int c0;
      int exp_stalls;
      frame_t o, e;
`ifdef FC_COLLECT_DOUBLE_BUF_EN
      exp_stalls = 0;
`else
      exp_stalls = 3;
`endif
      bus.m_ready = 1'b1;
      stalls = 0;
      c0 = cyc;
      for (int f = 0; f < 4; f++) drive_frame(N, W'(f * 40 + 7), 1);
      n_checks++;
      if (stalls != exp_stalls) begin
         n_fail++; $display("FAIL b2b_stalls: %0d idle s_ready cycles, required %0d",
                            stalls, exp_stalls);
      end
      n_checks++;
      if (acc_cyc - c0 + 1 != 4 * N + exp_stalls) begin
         n_fail++; $display("FAIL b2b_cycles: %0d cycles for %0d beats, required %0d",
                            acc_cyc - c0 + 1, 4 * N, 4 * N + exp_stalls);
      end
      wait_obs(4, ok);
      if (ok) begin
         for (int f = 0; f < 4; f++) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); void'(obs_cyc_q.pop_front());
            n_checks++;
            if (o.vec !== e.vec || o.err !== e.err) begin
               n_fail++;
               $display("FAIL b2b_frame %0d: m_vec[%0d]=%h err=%b, required %h err=%b", f,
                        first_diff(o.vec, e.vec), o.vec[first_diff(o.vec, e.vec)*W +: W], o.err,
                        e.vec[first_diff(o.vec, e.vec)*W +: W], e.err);
            end
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      bit ok;
      frame_t o, e;
      bus.m_ready = 1'b0;
`ifdef FC_COLLECT_DOUBLE_BUF_EN
      drive_frame(N, 8'h40, 0);
      @(negedge clk);
      n_checks++;
      if (bus.m_valid !== 1'b1) begin
         n_fail++; $display("FAIL rst_mid_pending: m_valid %b, required 1", bus.m_valid);
      end
      @(posedge clk); #1;
`endif
      for (int k = 0; k < 60; k++) send_beat(W'(8'hC0 + k), 1'b0);
      bus.s_valid = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.s_ready !== 1'b0) begin
         n_fail++; $display("FAIL rst_mid_s_ready: got %b, required 0", bus.s_ready);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.m_valid !== 1'b0) begin
         n_fail++; $display("FAIL rst_mid_m_valid: got %b, required 0", bus.m_valid);
      end
      n_checks++;
      if (pack_vec() !== '0) begin
         n_fail++; $display("FAIL rst_mid_m_vec: m_vec[%0d] nonzero",
                            first_diff(pack_vec(), '0));
      end
      @(posedge clk); #1;
      bus.m_ready = 1'b1;
      drive_frame(N, 8'hA0, 1);
      wait_obs(1, ok);
      repeat (4) @(posedge clk);
      #1;
      n_checks++;
      if (obs_q.size() != 1) begin
         n_fail++; $display("FAIL rst_mid_frames: %0d frames, required 1", obs_q.size());
      end
      if (ok) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); void'(obs_cyc_q.pop_front());
         n_checks++;
         if (o.vec !== e.vec || o.err !== e.err) begin
            n_fail++;
            $display("FAIL rst_mid_restart: m_vec[%0d]=%h err=%b, required %h err=%b",
                     first_diff(o.vec, e.vec), o.vec[first_diff(o.vec, e.vec)*W +: W], o.err,
                     e.vec[first_diff(o.vec, e.vec)*W +: W], e.err);
         end
      end
   endtask

   initial begin
      n_checks = 0; n_fail = 0; valid_cycles = 0; stalls = 0; acc_cyc = 0;
      test_reset();
      test_full_frame();
      test_short_frame();
      test_long_frame();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
